// File: rtl/ram_sched.sv
// -----------------------------------------------------------------------------
// ram_sched
//
// Purpose
//   Schedules accesses from three engines onto a single-port synchronous RAM
//   and performs a zero-fill sweep of the RAM on request.
//     * CGR and SQG issue writes; BC issues reads.
//     * One grant per cycle at most. Grants are combinational in the cycle
//       the request is accepted. The RAM command follows on ram_* one cycle
//       later.
//     * BC read data comes back on bc_rd_data with bc_rd_valid, two cycles
//       after bc_gnt.
//     * A clear writes zero to addresses 0 .. CLR_DEPTH-1, one word per
//       cycle. No grants are issued while it runs.
//
// Build option
//   RAM_SCHED_FIXED_PRIO_EN : when defined, arbitration is fixed priority
//                             (bc > cgr > sqg). When undefined (default), it
//                             is round-robin over bc, cgr, sqg.
//
// Parameters
//   ADDR_LEN   RAM address width
//   DATA_LEN   RAM data width
//   CLR_DEPTH  number of words zeroed by a clear
//
// Ports
//   CLK          in   clock; all state updates on the rising edge
//   RST          in   synchronous active-high reset
//   clr_start    in   one-cycle pulse that starts a clear
//   clr_busy     out  clear sweep in progress
//   clr_done     out  one-cycle pulse in the cycle the last clear write issues
//   cgr_req      in   CGR write request; addr/data held until cgr_gnt
//   cgr_addr     in   CGR write address
//   cgr_data     in   CGR write data
//   sqg_req      in   SQG write request; addr/data held until sqg_gnt
//   sqg_addr     in   SQG write address
//   sqg_data     in   SQG write data
//   bc_req       in   BC read request; addr held until bc_gnt
//   bc_addr      in   BC read address
//   cgr_gnt      out  CGR request accepted this cycle
//   sqg_gnt      out  SQG request accepted this cycle
//   bc_gnt       out  BC request accepted this cycle
//   bc_rd_valid  out  bc_rd_data valid (two cycles after bc_gnt)
//   bc_rd_data   out  read data returned to BC; zero when not valid
//   ram_en       out  RAM access strobe
//   ram_we       out  RAM write enable
//   ram_addr     out  RAM address
//   ram_wdata    out  RAM write data
//   ram_rd_data  in   RAM read data; valid one cycle after a read strobe
// -----------------------------------------------------------------------------
module ram_sched #(
   parameter int ADDR_LEN  = 16,
   parameter int DATA_LEN  = 8,
   parameter int CLR_DEPTH = 65536
) (
   input  logic                CLK,
   input  logic                RST,

   input  logic                clr_start,
   output logic                clr_busy,
   output logic                clr_done,

   input  logic                cgr_req,
   input  logic [ADDR_LEN-1:0] cgr_addr,
   input  logic [DATA_LEN-1:0] cgr_data,
   input  logic                sqg_req,
   input  logic [ADDR_LEN-1:0] sqg_addr,
   input  logic [DATA_LEN-1:0] sqg_data,
   input  logic                bc_req,
   input  logic [ADDR_LEN-1:0] bc_addr,

   output logic                cgr_gnt,
   output logic                sqg_gnt,
   output logic                bc_gnt,

   output logic                bc_rd_valid,
   output logic [DATA_LEN-1:0] bc_rd_data,

   output logic                ram_en,
   output logic                ram_we,
   output logic [ADDR_LEN-1:0] ram_addr,
   output logic [DATA_LEN-1:0] ram_wdata,
   input  logic [DATA_LEN-1:0] ram_rd_data
);

   // ---------------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------------
   localparam logic [0:0] SERVE = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   // The clear counter is one bit wider than the address, so a sweep of the
   // full 2^ADDR_LEN space still reaches its last value without wrapping.
   localparam logic [ADDR_LEN:0] CLR_LAST = (ADDR_LEN + 1)'(CLR_DEPTH - 1);
   localparam logic [ADDR_LEN:0] CLR_ONE  = (ADDR_LEN + 1)'(1);

   // Requester bit positions inside req_vec / gnt_vec.
   localparam int BC  = 0;
   localparam int CGR = 1;
   localparam int SQG = 2;

`ifdef RAM_SCHED_FIXED_PRIO_EN
`else
   // Round-robin pointer: the requester that currently has highest priority.
   localparam logic [1:0] PTR_BC  = 2'd0;
   localparam logic [1:0] PTR_CGR = 2'd1;
   localparam logic [1:0] PTR_SQG = 2'd2;

   logic [1:0] ptr_q;
`endif

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [0:0]          state_q;
   logic [ADDR_LEN:0]   clr_cnt_q;

   // Registered RAM command from a grant in the previous cycle.
   logic                cmd_en_q;
   logic                cmd_we_q;
   logic [ADDR_LEN-1:0] cmd_addr_q;
   logic [DATA_LEN-1:0] cmd_data_q;

   // A read strobe on the RAM last cycle means its data is on ram_rd_data now.
   logic                rd_valid_q;

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   logic       in_clear;
   logic       clr_last;
   logic       arb_ok;
   logic [2:0] req_vec;
   logic [2:0] gnt_vec;

   assign in_clear = (state_q == CLEAR);
   assign clr_last = in_clear && (clr_cnt_q == CLR_LAST);

   // Grants are withheld in the clr_start cycle, so nothing can be queued
   // behind the first clear write. They are also withheld under reset, so
   // that no command is half-accepted.
   assign arb_ok  = (state_q == SERVE) && !clr_start && !RST;
   assign req_vec = {sqg_req, cgr_req, bc_req};

   // NOTE: every signal written in an always_comb gets a default on entry;
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      gnt_vec = 3'b000;
      if (arb_ok) begin
`ifdef RAM_SCHED_FIXED_PRIO_EN
         if      (req_vec[BC])  gnt_vec[BC]  = 1'b1;
         else if (req_vec[CGR]) gnt_vec[CGR] = 1'b1;
         else if (req_vec[SQG]) gnt_vec[SQG] = 1'b1;
`else
         // Scan from the pointer in bc -> cgr -> sqg order, wrapping around.
         case (ptr_q)
            PTR_BC: begin
               if      (req_vec[BC])  gnt_vec[BC]  = 1'b1;
               else if (req_vec[CGR]) gnt_vec[CGR] = 1'b1;
               else if (req_vec[SQG]) gnt_vec[SQG] = 1'b1;
            end
            PTR_CGR: begin
               if      (req_vec[CGR]) gnt_vec[CGR] = 1'b1;
               else if (req_vec[SQG]) gnt_vec[SQG] = 1'b1;
               else if (req_vec[BC])  gnt_vec[BC]  = 1'b1;
            end
            default: begin
               if      (req_vec[SQG]) gnt_vec[SQG] = 1'b1;
               else if (req_vec[BC])  gnt_vec[BC]  = 1'b1;
               else if (req_vec[CGR]) gnt_vec[CGR] = 1'b1;
            end
         endcase
`endif
      end
   end

   assign bc_gnt  = gnt_vec[BC];
   assign cgr_gnt = gnt_vec[CGR];
   assign sqg_gnt = gnt_vec[SQG];

   // ---------------------------------------------------------------------------
   // Next RAM command, selected by the winning grant
   // ---------------------------------------------------------------------------
   logic                nxt_en;
   logic                nxt_we;
   logic [ADDR_LEN-1:0] nxt_addr;
   logic [DATA_LEN-1:0] nxt_data;

   always_comb begin
      nxt_en   = 1'b0;
      nxt_we   = 1'b0;
      nxt_addr = '0;
      nxt_data = '0;
      if (gnt_vec[BC]) begin
         nxt_en   = 1'b1;
         nxt_addr = bc_addr;
      end else if (gnt_vec[CGR]) begin
         nxt_en   = 1'b1;
         nxt_we   = 1'b1;
         nxt_addr = cgr_addr;
         nxt_data = cgr_data;
      end else if (gnt_vec[SQG]) begin
         nxt_en   = 1'b1;
         nxt_we   = 1'b1;
         nxt_addr = sqg_addr;
         nxt_data = sqg_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments only, so every
   // flop samples the values from before the edge regardless of statement
   // order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= SERVE;
         clr_cnt_q  <= '0;
         cmd_en_q   <= 1'b0;
         cmd_we_q   <= 1'b0;
         cmd_addr_q <= '0;
         cmd_data_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         case (state_q)
            SERVE: begin
               if (clr_start) begin
                  state_q   <= CLEAR;
                  clr_cnt_q <= '0;
               end
            end
            default: begin
               // clr_start is not looked at here: a running sweep cannot be
               // restarted.
               if (clr_last) begin
                  state_q   <= SERVE;
                  clr_cnt_q <= '0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + CLR_ONE;
               end
            end
         endcase

         cmd_en_q   <= nxt_en;
         cmd_we_q   <= nxt_we;
         cmd_addr_q <= nxt_addr;
         cmd_data_q <= nxt_data;

         // A read command already on the bus completes even if a clear
         // starts in the same cycle; the clear writes begin one cycle later.
         rd_valid_q <= cmd_en_q && !cmd_we_q;
      end
   end

`ifdef RAM_SCHED_FIXED_PRIO_EN
`else
   // The pointer moves just past the last winner and holds when idle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q <= PTR_BC;
      end else if (gnt_vec[BC]) begin
         ptr_q <= PTR_CGR;
      end else if (gnt_vec[CGR]) begin
         ptr_q <= PTR_SQG;
      end else if (gnt_vec[SQG]) begin
         ptr_q <= PTR_BC;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // During a sweep the RAM is driven straight from the counter. The grant
   // path is idle then (no grants in the start cycle or in CLEAR), so the
   // registered command is known to be empty and the two never overlap.
   assign ram_en    = in_clear || cmd_en_q;
   assign ram_we    = in_clear || cmd_we_q;
   assign ram_addr  = in_clear ? clr_cnt_q[ADDR_LEN-1:0] : cmd_addr_q;
   assign ram_wdata = in_clear ? '0 : cmd_data_q;

   assign clr_busy  = in_clear && !clr_last;
   assign clr_done  = clr_last;

   assign bc_rd_valid = rd_valid_q;
   assign bc_rd_data  = rd_valid_q ? ram_rd_data : '0;

endmodule

// File: tb/tb_ram_sched.sv
// -----------------------------------------------------------------------------
// tb_ram_sched
//
// Testbench for ram_sched (ADDR_LEN=16, DATA_LEN=8, CLR_DEPTH=8). The bench
// provides a synchronous RAM for the DUT to drive. It also keeps a reference
// model: an array holding the expected RAM contents, the arbitration rule
// stated as "the last winner goes to the back of the line", and the expected
// command and read-return pipelines.
// -----------------------------------------------------------------------------
module tb_ram_sched;

   localparam int AW    = 16;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic          clr_start;
   logic          clr_busy;
   logic          clr_done;
   logic          cgr_req;
   logic [AW-1:0] cgr_addr;
   logic [DW-1:0] cgr_data;
   logic          sqg_req;
   logic [AW-1:0] sqg_addr;
   logic [DW-1:0] sqg_data;
   logic          bc_req;
   logic [AW-1:0] bc_addr;
   logic          cgr_gnt;
   logic          sqg_gnt;
   logic          bc_gnt;
   logic          bc_rd_valid;
   logic [DW-1:0] bc_rd_data;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rd_data;

   ram_sched #(.ADDR_LEN(AW), .DATA_LEN(DW), .CLR_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
      .cgr_req(cgr_req), .cgr_addr(cgr_addr), .cgr_data(cgr_data),
      .sqg_req(sqg_req), .sqg_addr(sqg_addr), .sqg_data(sqg_data),
      .bc_req(bc_req), .bc_addr(bc_addr),
      .cgr_gnt(cgr_gnt), .sqg_gnt(sqg_gnt), .bc_gnt(bc_gnt),
      .bc_rd_valid(bc_rd_valid), .bc_rd_data(bc_rd_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rd_data(ram_rd_data)
   );

   always #5 CLK = ~CLK;

   // RAM device with a side port used to preload contents.
   logic [DW-1:0] ram_mem [0:(1<<AW)-1];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;

   always @(posedge CLK) begin
      if (pre_we) ram_mem[pre_addr] <= pre_data;
      else if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
      if (ram_en && !ram_we) ram_rd_data <= ram_mem[ram_addr];
   end

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   bit            m_clear;
   int            m_idx;
   int            m_last;
   int            m_win;
   bit            m_cmd_en;
   bit            m_cmd_we;
   logic [AW-1:0] m_cmd_addr;
   logic [DW-1:0] m_cmd_data;
   bit            m_rd1_v, m_rd2_v;
   logic [DW-1:0] m_rd1_d, m_rd2_d;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Winner index (0=bc, 1=cgr, 2=sqg) or -1 when nobody requests.
   function automatic int pick(input logic [2:0] r, input int last);
`ifdef RAM_SCHED_FIXED_PRIO_EN
      for (int k = 0; k < 3; k++) if (r[k]) return k;
`else
      for (int k = 1; k <= 3; k++) begin
         int c;
         c = (last + k) % 3;
         if (r[c]) return c;
      end
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_clear  = 1'b0;
      m_idx    = 0;
      m_last   = 2;       // so bc is first in line after reset
      m_cmd_en = 1'b0;
      m_cmd_we = 1'b0;
      m_rd1_v  = 1'b0;
      m_rd2_v  = 1'b0;
      m_rd1_d  = '0;
      m_rd2_d  = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_bc_gnt"}, bc_gnt, 0);
      check({tag, "_cgr_gnt"}, cgr_gnt, 0);
      check({tag, "_sqg_gnt"}, sqg_gnt, 0);
      check({tag, "_ram_en"}, ram_en, 0);
      check({tag, "_ram_we"}, ram_we, 0);
      check({tag, "_ram_addr"}, ram_addr, 0);
      check({tag, "_ram_wdata"}, ram_wdata, 0);
      check({tag, "_clr_busy"}, clr_busy, 0);
      check({tag, "_clr_done"}, clr_done, 0);
      check({tag, "_rd_valid"}, bc_rd_valid, 0);
      check({tag, "_rd_data"}, bc_rd_data, 0);
   endtask

   // Called 1 time unit after a rising edge, once the inputs for the cycle are
   // driven. It checks the cycle against the model, advances the model, and
   // returns 1 time unit after the next rising edge.
   task automatic run_cycle();
      int w;
      #1;
      w = -1;
      if (!RST) begin
         if (m_clear) begin
            check("clr_ram_en", ram_en, 1);
            check("clr_ram_we", ram_we, 1);
            check("clr_ram_addr", ram_addr, m_idx);
            check("clr_ram_wdata", ram_wdata, 0);
            check("clr_busy", clr_busy, m_idx != DEPTH - 1);
            check("clr_done", clr_done, m_idx == DEPTH - 1);
         end else begin
            if (!clr_start) w = pick({sqg_req, cgr_req, bc_req}, m_last);
            check("ram_en", ram_en, m_cmd_en);
            if (m_cmd_en) begin
               check("ram_we", ram_we, m_cmd_we);
               check("ram_addr", ram_addr, m_cmd_addr);
               if (m_cmd_we) check("ram_wdata", ram_wdata, m_cmd_data);
            end
            check("idle_busy", clr_busy, 0);
            check("idle_done", clr_done, 0);
         end
         check("bc_gnt", bc_gnt, w == 0);
         check("cgr_gnt", cgr_gnt, w == 1);
         check("sqg_gnt", sqg_gnt, w == 2);
         check("rd_valid", bc_rd_valid, m_rd2_v);
         if (m_rd2_v) check("rd_data", bc_rd_data, m_rd2_d);
      end
      m_win = w;
      // Whatever clear write is on the bus this cycle reaches the RAM, even
      // in a reset cycle.
      if (m_clear) ref_mem[m_idx] = '0;
      if (RST) begin
         model_reset();
      end else begin
         m_rd2_v  = m_rd1_v;
         m_rd2_d  = m_rd1_d;
         m_rd1_v  = (w == 0);
         m_rd1_d  = (w == 0) ? ref_mem[bc_addr] : '0;
         m_cmd_en = (w >= 0);
         m_cmd_we = (w > 0);
         case (w)
            0:       begin m_cmd_addr = bc_addr;  m_cmd_data = '0;       end
            1:       begin m_cmd_addr = cgr_addr; m_cmd_data = cgr_data; end
            2:       begin m_cmd_addr = sqg_addr; m_cmd_data = sqg_data; end
            default: begin m_cmd_addr = '0;       m_cmd_data = '0;       end
         endcase
         if (w > 0) ref_mem[m_cmd_addr] = m_cmd_data;
         if (w >= 0) m_last = w;
         if (m_clear) begin
            if (m_idx == DEPTH - 1) begin
               m_clear = 1'b0;
               m_idx   = 0;
            end else begin
               m_idx++;
            end
         end else if (clr_start) begin
            m_clear = 1'b1;
            m_idx   = 0;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      ref_mem[a] = d;
      @(posedge CLK);
      #1;
      pre_we = 1'b0;
   endtask

   task automatic idle_inputs();
      clr_start = 0;
      bc_req = 0;  cgr_req = 0;  sqg_req = 0;
      bc_addr = '0; cgr_addr = '0; sqg_addr = '0;
      cgr_data = '0; sqg_data = '0;
   endtask

   // ---------------------------------------------------------------------------
   // Directed and random sequence
   // ---------------------------------------------------------------------------
   initial begin
      logic [DW-1:0] saved;
      logic [2:0]    exp_gnt [6];

      idle_inputs();
      RST = 1'b1;
      model_reset();
      m_win = -1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b0;

      // Reset state
      check_all_zero("reset");

      // Preload: 0..15 random, 0x12 = 0x5A, 0x100 = 0x33
      for (int a = 0; a < 16; a++) preload(AW'(a), DW'($urandom));
      preload(16'h0012, 8'h5A);
      preload(16'h0100, 8'h33);

      // Clear with requests pending throughout; a second clr_start at
      // cycle 3 must be ignored.
      for (int c = 0; c <= 10; c++) begin
         clr_start = (c == 0) || (c == 3);
         bc_req  = (c <= 8); bc_addr  = 16'h0001;
         cgr_req = (c <= 8); cgr_addr = 16'h0002; cgr_data = 8'hC1;
         sqg_req = (c <= 8); sqg_addr = 16'h0003; sqg_data = 8'hD1;
         #1;
         if (c <= 8) begin
            check("clr_no_gnt", {bc_gnt, cgr_gnt, sqg_gnt}, 0);
         end
         check("clr_seq_en", ram_en, (c >= 1) && (c <= 8));
         if ((c >= 1) && (c <= 8)) begin
            check("clr_seq_addr", ram_addr, c - 1);
            check("clr_seq_we", ram_we, 1);
         end
         check("clr_seq_busy", clr_busy, (c >= 1) && (c <= 7));
         check("clr_seq_done", clr_done, c == 8);
         run_cycle();
      end
      idle_inputs();

      // BC read of 0x0012 (holds 0x5A)
      bc_req = 1; bc_addr = 16'h0012;
      #1; check("rd_gnt_n", bc_gnt, 1);
      run_cycle();
      bc_req = 0;
      #1;
      check("rd_en_n1", ram_en, 1);
      check("rd_we_n1", ram_we, 0);
      check("rd_addr_n1", ram_addr, 16'h0012);
      run_cycle();
      #1;
      check("rd_valid_n2", bc_rd_valid, 1);
      check("rd_data_n2", bc_rd_data, 8'h5A);
      run_cycle();
      #1; check("rd_valid_n3", bc_rd_valid, 0);
      run_cycle();

      // Write of 0x07 to 0x0100, then a read of 0x0100 the next cycle
      cgr_req = 1; cgr_addr = 16'h0100; cgr_data = 8'h07;
      #1; check("raw_cgr_gnt", cgr_gnt, 1);
      run_cycle();
      cgr_req = 0; bc_req = 1; bc_addr = 16'h0100;
      #1; check("raw_bc_gnt", bc_gnt, 1);
      run_cycle();
      bc_req = 0;
      run_cycle();
      #1;
      check("raw_valid", bc_rd_valid, 1);
      check("raw_data", bc_rd_data, 8'h07);
      run_cycle();

      // Read in flight when a clear starts
      saved = ref_mem[16'h000A];
      bc_req = 1; bc_addr = 16'h000A;
      #1; check("fly_gnt", bc_gnt, 1);
      run_cycle();
      bc_req = 0; clr_start = 1;
      run_cycle();
      clr_start = 0;
      #1;
      check("fly_valid", bc_rd_valid, 1);
      check("fly_data", bc_rd_data, saved);
      check("fly_clr_en", ram_en, 1);
      check("fly_clr_addr", ram_addr, 0);
      for (int c = 0; c < DEPTH + 2; c++) run_cycle();

      // Everyone requests continuously, starting from reset
      RST = 1;
      run_cycle();
      RST = 0;
`ifdef RAM_SCHED_FIXED_PRIO_EN
      exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
      exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
      bc_req  = 1; bc_addr  = 16'h0003;
      cgr_req = 1; cgr_addr = 16'h0004; cgr_data = 8'hA1;
      sqg_req = 1; sqg_addr = 16'h0005; sqg_data = 8'hB2;
      for (int c = 0; c < 6; c++) begin
         #1; check("arb_seq", {sqg_gnt, cgr_gnt, bc_gnt}, exp_gnt[c]);
         run_cycle();
      end
      idle_inputs();
      for (int c = 0; c < 3; c++) run_cycle();

      // Reset in the cycle where the clear is writing address 3
      clr_start = 1;
      run_cycle();
      clr_start = 0;
      for (int c = 0; c < 3; c++) run_cycle();
      RST = 1;
      #1; check("abort_addr3", ram_addr, 3);
      run_cycle();
      RST = 0;
      check_all_zero("abort");
      for (int c = 0; c < 10; c++) begin
         #1; check("abort_no_done", clr_done, 0);
         run_cycle();
      end
      clr_start = 1;
      run_cycle();
      clr_start = 0;
      #1;
      check("restart_en", ram_en, 1);
      check("restart_addr", ram_addr, 0);
      for (int c = 0; c < DEPTH + 1; c++) run_cycle();

      // Random traffic; each requester holds until its model grant
      for (int i = 0; i < 400; i++) begin
         clr_start = ($urandom_range(0, 59) == 0);
         if (!bc_req && $urandom_range(0, 2) == 0) begin
            bc_req = 1; bc_addr = AW'($urandom_range(0, 15));
         end
         if (!cgr_req && $urandom_range(0, 2) == 0) begin
            cgr_req = 1; cgr_addr = AW'($urandom_range(0, 15)); cgr_data = DW'($urandom);
         end
         if (!sqg_req && $urandom_range(0, 2) == 0) begin
            sqg_req = 1; sqg_addr = AW'($urandom_range(0, 15)); sqg_data = DW'($urandom);
         end
         run_cycle();
         if (m_win == 0) bc_req  = 0;
         if (m_win == 1) cgr_req = 0;
         if (m_win == 2) sqg_req = 0;
      end
      idle_inputs();
      for (int c = 0; c < DEPTH + 4; c++) run_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_sched.md
RAM_SCHED -- requirements
Module: ram_sched

Interface
REQ-001 Parameter ADDR_LEN, default 16: map RAM address width.
REQ-002 Parameter DATA_LEN, default 8: map RAM data width.
REQ-003 Parameter CLR_DEPTH, default 65536: number of words swept by a clear, from address 0 to CLR_DEPTH-1.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous active-high reset.
- clr_start  in  1  one-cycle pulse that starts a RAM clear.
- clr_busy  out  1  high while a clear sweep is in progress.
- clr_done  out  1  one-cycle pulse when a sweep completes.
- cgr_req / sqg_req  in  1  write requests from the CGR and SQG engines.
- cgr_addr / sqg_addr  in  ADDR_LEN  write addresses.
- cgr_data / sqg_data  in  DATA_LEN  write data.
- bc_req  in  1  read request from the BC engine.
- bc_addr  in  ADDR_LEN  read address.
- cgr_gnt / sqg_gnt / bc_gnt  out  1  request accepted this cycle.
- bc_rd_valid  out  1  bc_rd_data is valid.
- bc_rd_data  out  DATA_LEN  read data returned to BC.
- ram_en / ram_we  out  1  RAM access strobe and write enable.
- ram_addr  out  ADDR_LEN  RAM address.
- ram_wdata  out  DATA_LEN  RAM write data.
- ram_rd_data  in  DATA_LEN  RAM read data; synchronous read, one cycle after ram_en with ram_we low.

Function
REQ-005 The FSM SHALL have states SERVE and CLEAR; reset enters SERVE.
REQ-006 In SERVE, clr_start SHALL move the FSM to CLEAR on the next edge, and no grant SHALL be issued in the clr_start cycle.
REQ-007 In CLEAR:
- one zero-write per cycle (ram_en=1, ram_we=1, ram_wdata=0);
- ram_addr runs 0 to CLR_DEPTH-1;
- clr_busy=1 and all grants are 0.
REQ-008 After the write to CLR_DEPTH-1 is issued, clr_done SHALL pulse for exactly one cycle, clr_busy SHALL drop in that same cycle, and the FSM SHALL return to SERVE.
REQ-009 clr_start SHALL be ignored while in CLEAR.
REQ-010 In SERVE, at most one grant SHALL be high per cycle; a grant is combinational in the acceptance cycle and is only given to a requester whose req is high.
REQ-011 Requesters SHALL hold req, addr and data stable until they see their grant.
REQ-012 The RAM command for a grant in cycle N SHALL be registered onto ram_* in cycle N+1; ram_en=0 in every cycle with no command.
REQ-013 For a bc_gnt in cycle N, bc_rd_valid SHALL be high for one cycle at N+2 with bc_rd_data = ram_rd_data.
REQ-014 Accesses SHALL reach the RAM in grant order, so a write granted before a read to the same address is visible to that read.
REQ-015 A read already in flight when a clear starts SHALL still complete and return bc_rd_valid.
REQ-016 The clear address counter SHALL be ADDR_LEN+1 bits wide so that CLR_DEPTH=2^ADDR_LEN terminates without wrap.

Reset
REQ-017 While RST is high at an edge:
- FSM goes to SERVE, clear counter to 0, arbitration pointer to bc;
- all outputs go to 0;
- any in-flight read is discarded (no bc_rd_valid).
REQ-018 Reset asserted mid-clear SHALL abort the sweep with no clr_done pulse.

Configuration
REQ-019 With macro RAM_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: bc > cgr > sqg.
REQ-020 Without RAM_SCHED_FIXED_PRIO_EN, arbitration SHALL be round-robin over bc, cgr, sqg in that order: the last-granted requester becomes lowest priority, and the pointer updates only when a grant is issued.

Verification
REQ-021 The bench SHALL cover:
- Clear, CLR_DEPTH=8, clr_start at cycle 0 -> zero-writes to addresses 0..7 in cycles 1..8; clr_done pulses at cycle 8; clr_busy high in cycles 1..7; no grants in cycles 0..8.
- bc_req with bc_addr=0x0012 and RAM word 0x5A -> bc_gnt at N; ram_en=1, ram_we=0, ram_addr=0x0012 at N+1; bc_rd_valid=1, bc_rd_data=0x5A at N+2.
- cgr, sqg and bc all requesting continuously, round-robin build -> grants bc, cgr, sqg, bc, cgr, sqg; with RAM_SCHED_FIXED_PRIO_EN -> bc every cycle.
- cgr write of 0x07 to 0x0100 granted one cycle before a bc read of 0x0100 -> bc_rd_data=0x07.
- clr_start one cycle after a bc_gnt -> bc_rd_valid still asserts; clear sweep follows.
- RST at clear address 3 -> all outputs 0 next cycle; no clr_done; a new clr_start restarts the sweep at address 0.
